memory_arbiter: RTL

- Shares one single-port Memory instance between the instruction-fetch requester (I, read-only) and the data-access requester (D, read/write) of the five-stage pipeline CPU.
- Sequences each access over a fixed number of cycles.
- Returns read data through registered one-cycle ready pulses.
- Raises per-requester stall signals so the pipeline can freeze PC, IF_ID and later stages while waiting.

---
 rtl/memory_arbiter_pkg.sv | 15 +
 rtl/memory_arbiter_if.sv | 45 ++++
 rtl/memory_arbiter_access_timer.sv | 38 +++
 rtl/memory_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_t : arbiter state encoding (IDLE / BUSY_I / BUSY_D); the unused
//                 encoding 2'd3 is treated as illegal and recovers to IDLE.
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
// Bundles the fetch requester (i_*), data requester (d_*) and single-port
// memory (mem_*) signals of the memory arbiter.
//   modport slave  : the arbiter's view (requests and mem_read_data in,
//                    ready/rdata/stall and memory controls out)
//   modport master : the surrounding system's view (the opposite directions)
// -----------------------------------------------------------------------------
interface memory_arbiter_if #(
   parameter int unsigned WIDTH = 32
);

   logic             i_req;
   logic [WIDTH-1:0] i_addr;
   logic             i_ready;
   logic [WIDTH-1:0] i_rdata;
   logic             i_stall;

   logic             d_req;
   logic             d_we;
   logic [WIDTH-1:0] d_addr;
   logic [WIDTH-1:0] d_wdata;
   logic             d_ready;
   logic [WIDTH-1:0] d_rdata;
   logic             d_stall;

   logic [WIDTH-1:0] mem_address;
   logic             mem_read_enable;
   logic             mem_write_enable;
   logic [WIDTH-1:0] mem_write_data;
   logic [WIDTH-1:0] mem_read_data;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
      output i_ready, i_rdata, i_stall, d_ready, d_rdata, d_stall,
             mem_address, mem_read_enable, mem_write_enable, mem_write_data
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
      input  i_ready, i_rdata, i_stall, d_ready, d_rdata, d_stall,
             mem_address, mem_read_enable, mem_write_enable, mem_write_data
   );

endinterface

// File: rtl/memory_arbiter_access_timer.sv
// -----------------------------------------------------------------------------
// memory_arbiter_access_timer
// Loadable down-counter that times how long the memory is held per access.
//   clock      : system clock
//   reset      : asynchronous active-low reset (count cleared to 0)
//   load       : load load_value (has priority over dec)
//   load_value : value loaded on load
//   dec        : decrement by one, holding at 0
//   zero       : count is 0
// -----------------------------------------------------------------------------
module memory_arbiter_access_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   always_comb begin
      zero = (count == '0);
   end

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Shares one single-port memory between the instruction-fetch requester (I,
// read-only) and the data requester (D, read/write). Each access holds the
// memory for LATENCY cycles, then returns a registered one-cycle ready pulse.
// D has priority, but after MAX_D_STREAK consecutive D grants with I waiting,
// I is served.
//   clock : system clock
//   reset : asynchronous active-low reset; aborts any access in flight
//   bus   : memory_arbiter_if.slave (requester handshakes + memory port)
// -----------------------------------------------------------------------------
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned LATENCY      = 2,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic             clock,
   input  logic             reset,
   memory_arbiter_if.slave  bus
);

   localparam int unsigned   TW         = $clog2(LATENCY) + 1;
   localparam int unsigned   SW         = $clog2(MAX_D_STREAK + 1);
   localparam logic [TW-1:0] LOAD_VAL   = TW'(LATENCY - 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   arb_state_t       state, state_next;
   logic [SW-1:0]    streak;
   logic [WIDTH-1:0] addr_q, wdata_q;
   logic             we_q;
   logic             i_ready_q, d_ready_q;
   logic [WIDTH-1:0] i_rdata_q, d_rdata_q;
   logic             i_elig, d_elig, grant_d, grant_i;
   logic             busy, done, timer_zero;

   // A requester whose ready pulse is high right now is not eligible, so a
   // request still held during its completion cycle is not granted twice.
   always_comb begin
      i_elig  = bus.i_req & ~i_ready_q;
      d_elig  = bus.d_req & ~d_ready_q;
      grant_d = (state == ARB_IDLE) && d_elig && ((streak < STREAK_MAX) || !i_elig);
      grant_i = (state == ARB_IDLE) && !grant_d && i_elig;
      busy    = (state == ARB_BUSY_I) || (state == ARB_BUSY_D);
      done    = busy && timer_zero;
   end

   memory_arbiter_access_timer #(
      .W (TW)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (grant_d | grant_i),
      .load_value (LOAD_VAL),
      .dec        (busy),
      .zero       (timer_zero)
   );

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ARB_IDLE: begin
            if (grant_d) begin
               state_next = ARB_BUSY_D;
            end else if (grant_i) begin
               state_next = ARB_BUSY_I;
            end
         end
         ARB_BUSY_I, ARB_BUSY_D: begin
            if (timer_zero) begin
               state_next = ARB_IDLE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   // Outputs: memory controls come straight from the state so an asynchronous
   // reset drops the enables immediately.
   always_comb begin
      bus.mem_address      = '0;
      bus.mem_read_enable  = 1'b0;
      bus.mem_write_enable = 1'b0;
      bus.mem_write_data   = '0;
      case (state)
         ARB_BUSY_I: begin
            bus.mem_address     = addr_q;
            bus.mem_read_enable = 1'b1;
         end
         ARB_BUSY_D: begin
            bus.mem_address      = addr_q;
            bus.mem_read_enable  = ~we_q;
            bus.mem_write_enable = we_q;
            bus.mem_write_data   = wdata_q;
         end
         default: ;
      endcase
      bus.i_ready = i_ready_q;
      bus.i_rdata = i_rdata_q;
      bus.i_stall = bus.i_req & ~i_ready_q;
      bus.d_ready = d_ready_q;
      bus.d_rdata = d_rdata_q;
      bus.d_stall = bus.d_req & ~d_ready_q;
   end

   // Access latches, completion pulses and read data
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         if (grant_d) begin
            addr_q  <= bus.d_addr;
            we_q    <= bus.d_we;
            wdata_q <= bus.d_wdata;
         end else if (grant_i) begin
            addr_q  <= bus.i_addr;
         end
         if (done) begin
            if (state == ARB_BUSY_I) begin
               i_rdata_q <= bus.mem_read_data;
               i_ready_q <= 1'b1;
            end else begin
               if (!we_q) begin
                  d_rdata_q <= bus.mem_read_data;
               end
               d_ready_q <= 1'b1;
            end
         end
      end
   end

   // Consecutive D grants taken while I was waiting
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         streak <= '0;
      end else if (grant_d) begin
         if (!i_elig) begin
            streak <= '0;
         end else if (streak != STREAK_MAX) begin
            streak <= streak + SW'(1);
         end
      end else if (grant_i) begin
         streak <= '0;
      end
   end

endmodule
